// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared codes for the ALU request arbiter
// Purpose: unit-select codes, logic-unit function codes, FSM state encoding
//          and the opcode-to-unit-enable decoder.
// Ports:   none (package).
package alu_pkg;

   localparam logic [1:0] UNIT_ARITH = 2'b00;
   localparam logic [1:0] UNIT_LOGIC = 2'b01;
   localparam logic [1:0] UNIT_CMP   = 2'b10;
   localparam logic [1:0] UNIT_SHIFT = 2'b11;

   localparam logic [1:0] LOGIC_AND  = 2'b00;
   localparam logic [1:0] LOGIC_OR   = 2'b01;
   localparam logic [1:0] LOGIC_NAND = 2'b10;
   localparam logic [1:0] LOGIC_NOR  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_t;

   // Returns {shift, cmp, logic, arith}, exactly one bit set.
   function automatic logic [3:0] unit_enables(input logic [1:0] unit);
      logic [3:0] en;
      case (unit)
         UNIT_ARITH: en = 4'b0001;
         UNIT_LOGIC: en = 4'b0010;
         UNIT_CMP:   en = 4'b0100;
         default:    en = 4'b1000;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin picker over NUM_REQ requesters
// Purpose: picks the first set request at or after (i_last+1), wrapping.
// Ports:
//   i_req  [NUM_REQ] request vector
//   i_last [ID_W]    index of the previous grant
//   i_en             picker enable; grant is all-zero when low
//   o_gnt  [NUM_REQ] one-hot grant
//   o_idx  [ID_W]    encoded grant index (0 when no grant)
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 3
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_last,
   input  logic               i_en,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [ID_W-1:0]    o_idx
);

   logic [NUM_REQ-1:0] w_hi;
   logic [NUM_REQ-1:0] w_pick;

   // Requests above the last grant take priority; if none, wrap to the
   // lowest set request overall. Equivalent to a rotating search.
   always_comb begin
      w_hi = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_hi[i] = i_req[i] && (i > int'(i_last));
      end
      w_pick = (|w_hi) ? w_hi : i_req;
   end

   // Descending scan so the lowest candidate is the final assignment.
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (i_en && w_pick[i]) begin
            o_gnt    = '0;
            o_gnt[i] = 1'b1;
            o_idx    = ID_W'(i);
         end
      end
   end

endmodule

// File: rtl/alu_op_arbiter.sv
// rtl/alu_op_arbiter.sv - shares one ALU between NUM_REQ requesters
// Purpose: round-robin accept, one-cycle unit enable, result capture and
//          tagged response handshake. Optional WAIT timeout enabled by the
//          macro ALU_OP_ARBITER_TIMEOUT_EN.
// Ports:
//   CLK, RST                  clock, synchronous active-high reset
//   REQ_VALID/REQ_READY       per-requester request handshake
//   REQ_A, REQ_B, REQ_FUN     packed per-requester operands and opcode
//   ALU_A, ALU_B, ALU_FUN     operands and function code to the ALU
//   *_Enable                  unit enables (arith, logic, cmp, shift)
//   ALU_OUT, OUT_VALID        muxed unit result and flag
//   RSP_VALID/RSP_READY       response handshake
//   RSP_ID, RSP_DATA, RSP_ERR response tag, data and timeout error
module alu_op_arbiter #(
   parameter int WIDTH   = 16,
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 3,
   parameter int TIMEOUT = 8
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic [NUM_REQ-1:0]       REQ_VALID,
   output logic [NUM_REQ-1:0]       REQ_READY,
   input  logic [NUM_REQ*WIDTH-1:0] REQ_A,
   input  logic [NUM_REQ*WIDTH-1:0] REQ_B,
   input  logic [NUM_REQ*4-1:0]     REQ_FUN,
   output logic [WIDTH-1:0]         ALU_A,
   output logic [WIDTH-1:0]         ALU_B,
   output logic [1:0]               ALU_FUN,
   output logic                     Arith_Enable,
   output logic                     Logic_Enable,
   output logic                     CMP_Enable,
   output logic                     SHIFT_Enable,
   input  logic [WIDTH-1:0]         ALU_OUT,
   input  logic                     OUT_VALID,
   output logic                     RSP_VALID,
   input  logic                     RSP_READY,
   output logic [ID_W-1:0]          RSP_ID,
   output logic [WIDTH-1:0]         RSP_DATA,
   output logic                     RSP_ERR
);

   import alu_pkg::*;

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   state_t             r_state;
   state_t             w_next;
   logic [NUM_REQ-1:0] w_gnt;
   logic [ID_W-1:0]    w_idx;
   logic               w_accept;
   logic               w_timeout;
   logic [3:0]         w_en;

   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [3:0]         r_fun;
   logic [ID_W-1:0]    r_id;
   logic [ID_W-1:0]    r_last;
   logic               r_rsp_valid;
   logic [WIDTH-1:0]   r_rsp_data;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .i_req  (REQ_VALID),
      .i_last (r_last),
      .i_en   (r_state == IDLE),
      .o_gnt  (w_gnt),
      .o_idx  (w_idx)
   );

   assign w_accept  = |w_gnt;
   assign REQ_READY = w_gnt;

`ifdef ALU_OP_ARBITER_TIMEOUT_EN
   logic [CNT_W-1:0] r_cnt;
   logic             r_rsp_err;

   // Fires on the last of TIMEOUT consecutive WAIT cycles without a result.
   assign w_timeout = (r_state == WAIT) && !OUT_VALID &&
                      (r_cnt == CNT_W'(TIMEOUT - 1));
   assign RSP_ERR   = r_rsp_err;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt     <= '0;
         r_rsp_err <= 1'b0;
      end else begin
         if (r_state == ISSUE) begin
            r_cnt <= '0;
         end else if (r_state == WAIT) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (r_state == WAIT && !OUT_VALID && w_timeout) begin
            r_rsp_err <= 1'b1;
         end else if (r_state == RESP && RSP_READY) begin
            r_rsp_err <= 1'b0;
         end
      end
   end
`else
   logic [CNT_W-1:0] w_unused_cnt;

   assign w_unused_cnt = '0;
   assign w_timeout    = 1'b0;
   assign RSP_ERR      = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_en    = 4'b0000;
      ALU_A   = '0;
      ALU_B   = '0;
      ALU_FUN = 2'b00;
      case (r_state)
         IDLE: begin
            if (w_accept) w_next = ISSUE;
         end
         ISSUE: begin
            ALU_A   = r_a;
            ALU_B   = r_b;
            ALU_FUN = r_fun[1:0];
            w_en    = unit_enables(r_fun[3:2]);
            w_next  = WAIT;
         end
         WAIT: begin
            ALU_A   = r_a;
            ALU_B   = r_b;
            ALU_FUN = r_fun[1:0];
            if (OUT_VALID || w_timeout) w_next = RESP;
         end
         default: begin
            ALU_A   = r_a;
            ALU_B   = r_b;
            ALU_FUN = r_fun[1:0];
            if (RSP_READY) w_next = IDLE;
         end
      endcase
   end

   assign Arith_Enable = w_en[0];
   assign Logic_Enable = w_en[1];
   assign CMP_Enable   = w_en[2];
   assign SHIFT_Enable = w_en[3];

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_a         <= '0;
         r_b         <= '0;
         r_fun       <= '0;
         r_id        <= '0;
         r_last      <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_a    <= REQ_A[w_idx*WIDTH +: WIDTH];
                  r_b    <= REQ_B[w_idx*WIDTH +: WIDTH];
                  r_fun  <= REQ_FUN[w_idx*4 +: 4];
                  r_id   <= w_idx;
                  r_last <= w_idx;
               end
            end
            WAIT: begin
               if (OUT_VALID) begin
                  r_rsp_data  <= ALU_OUT;
                  r_rsp_valid <= 1'b1;
               end else if (w_timeout) begin
                  r_rsp_data  <= '0;
                  r_rsp_valid <= 1'b1;
               end
            end
            RESP: begin
               if (RSP_READY) r_rsp_valid <= 1'b0;
            end
            default: begin
            end
         endcase
      end
   end

   assign RSP_VALID = r_rsp_valid;
   assign RSP_ID    = r_id;
   assign RSP_DATA  = r_rsp_data;

endmodule

// File: tb/tb_alu_op_arbiter.sv
// tb/tb_alu_op_arbiter.sv - directed self-checking bench for alu_op_arbiter
module tb_alu_op_arbiter;

   import alu_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic [1:0]  REQ_VALID;
   logic [1:0]  REQ_READY;
   logic [31:0] REQ_A;
   logic [31:0] REQ_B;
   logic [7:0]  REQ_FUN;
   logic [15:0] ALU_A;
   logic [15:0] ALU_B;
   logic [1:0]  ALU_FUN;
   logic        Arith_Enable;
   logic        Logic_Enable;
   logic        CMP_Enable;
   logic        SHIFT_Enable;
   logic [15:0] ALU_OUT = 16'h0000;
   logic        OUT_VALID = 1'b0;
   logic        RSP_VALID;
   logic        RSP_READY;
   logic [2:0]  RSP_ID;
   logic [15:0] RSP_DATA;
   logic        RSP_ERR;

   logic        alu_kill = 1'b0;
   int          total = 0;
   int          bad = 0;
   int          exp_id;
   logic [15:0] exp_data;
   logic [3:0]  en;

   assign en = {SHIFT_Enable, CMP_Enable, Logic_Enable, Arith_Enable};

   alu_op_arbiter #(
      .WIDTH   (16),
      .NUM_REQ (2),
      .ID_W    (3),
      .TIMEOUT (8)
   ) dut (
      .CLK          (CLK),
      .RST          (RST),
      .REQ_VALID    (REQ_VALID),
      .REQ_READY    (REQ_READY),
      .REQ_A        (REQ_A),
      .REQ_B        (REQ_B),
      .REQ_FUN      (REQ_FUN),
      .ALU_A        (ALU_A),
      .ALU_B        (ALU_B),
      .ALU_FUN      (ALU_FUN),
      .Arith_Enable (Arith_Enable),
      .Logic_Enable (Logic_Enable),
      .CMP_Enable   (CMP_Enable),
      .SHIFT_Enable (SHIFT_Enable),
      .ALU_OUT      (ALU_OUT),
      .OUT_VALID    (OUT_VALID),
      .RSP_VALID    (RSP_VALID),
      .RSP_READY    (RSP_READY),
      .RSP_ID       (RSP_ID),
      .RSP_DATA     (RSP_DATA),
      .RSP_ERR      (RSP_ERR)
   );

   always #5 CLK = ~CLK;

   // ALU stand-in: registered result and flag one cycle after any enable.
   always @(posedge CLK) begin
      OUT_VALID <= 1'b0;
      if ((|en) && !alu_kill) begin
         OUT_VALID <= 1'b1;
         if (Arith_Enable) begin
            ALU_OUT <= (ALU_FUN == 2'b00) ? ALU_A + ALU_B : ALU_A - ALU_B;
         end else if (Logic_Enable) begin
            case (ALU_FUN)
               LOGIC_AND:  ALU_OUT <= ALU_A & ALU_B;
               LOGIC_OR:   ALU_OUT <= ALU_A | ALU_B;
               LOGIC_NAND: ALU_OUT <= ~(ALU_A & ALU_B);
               LOGIC_NOR:  ALU_OUT <= ~(ALU_A | ALU_B);
               default:    ALU_OUT <= 16'h0000;
            endcase
         end else if (CMP_Enable) begin
            ALU_OUT <= (ALU_A == ALU_B) ? 16'h0001 : 16'h0000;
         end else begin
            ALU_OUT <= ALU_A >> 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      RST       = 1'b1;
      REQ_VALID = 2'b00;
      REQ_A     = '0;
      REQ_B     = '0;
      REQ_FUN   = '0;
      RSP_READY = 1'b1;

      // Reset held for two cycles
      step();
      step();
      #1;
      chk("rst_rsp_valid", RSP_VALID, 0);
      chk("rst_rsp_id",    RSP_ID, 0);
      chk("rst_rsp_data",  RSP_DATA, 0);
      chk("rst_rsp_err",   RSP_ERR, 0);
      chk("rst_req_ready", REQ_READY, 0);
      chk("rst_alu_a",     ALU_A, 0);
      chk("rst_alu_b",     ALU_B, 0);
      chk("rst_alu_fun",   ALU_FUN, 0);
      chk("rst_enables",   en, 0);
      RST = 1'b0;
      step();
      #1;
      chk("idle_no_req_ready", REQ_READY, 0);

      // Single logic AND from requester 0
      REQ_A[15:0]  = 16'h00F0;
      REQ_B[15:0]  = 16'h0FF0;
      REQ_FUN[3:0] = 4'b0100;
      REQ_VALID    = 2'b01;
      #1;
      chk("and_req_ready", REQ_READY, 2'b01);
      step();
      REQ_VALID = 2'b00;
      #1;
      chk("and_issue_en",    en, 4'b0010);
      chk("and_issue_a",     ALU_A, 16'h00F0);
      chk("and_issue_b",     ALU_B, 16'h0FF0);
      chk("and_issue_fun",   ALU_FUN, 2'b00);
      chk("and_issue_ready", REQ_READY, 0);
      step();
      #1;
      chk("and_wait_en",    en, 0);
      chk("and_wait_valid", RSP_VALID, 0);
      chk("and_wait_a",     ALU_A, 16'h00F0);
      step();
      #1;
      chk("and_rsp_valid", RSP_VALID, 1);
      chk("and_rsp_data",  RSP_DATA, 16'h00F0);
      chk("and_rsp_id",    RSP_ID, 0);
      chk("and_rsp_err",   RSP_ERR, 0);
      step();
      #1;
      chk("and_done_valid", RSP_VALID, 0);
      chk("and_idle_a",     ALU_A, 0);

      // Contention: last grant was 0, so rotation runs 1,0,1,0
      REQ_A[31:16]  = 16'h0000;
      REQ_B[31:16]  = 16'h0000;
      REQ_FUN[7:4]  = 4'b0111;
      REQ_VALID     = 2'b11;
      for (int g = 0; g < 4; g++) begin
         exp_id   = (g % 2 == 0) ? 1 : 0;
         exp_data = (exp_id == 1) ? 16'hFFFF : 16'h00F0;
         #1;
         chk("rr_ready", REQ_READY, 32'd1 << exp_id);
         step();
         #1;
         chk("rr_issue_en",  en, 4'b0010);
         chk("rr_issue_fun", ALU_FUN, (exp_id == 1) ? 2'b11 : 2'b00);
         step();
         step();
         #1;
         chk("rr_rsp_valid", RSP_VALID, 1);
         chk("rr_rsp_id",    RSP_ID, exp_id);
         chk("rr_rsp_data",  RSP_DATA, exp_data);
         step();
      end

      // Backpressure: req0 ADD 3+4, req1 pending while response is held
      REQ_A[15:0]  = 16'h0003;
      REQ_B[15:0]  = 16'h0004;
      REQ_FUN[3:0] = 4'b0000;
      REQ_VALID    = 2'b01;
      RSP_READY    = 1'b0;
      #1;
      chk("bp_ready0", REQ_READY, 2'b01);
      step();
      REQ_VALID = 2'b10;
      #1;
      chk("bp_issue_en", en, 4'b0001);
      chk("bp_issue_ready", REQ_READY, 0);
      step();
      step();
      #1;
      for (int c = 0; c < 5; c++) begin
         if (c > 0) begin
            step();
            #1;
         end
         chk("bp_hold_valid", RSP_VALID, 1);
         chk("bp_hold_data",  RSP_DATA, 16'h0007);
         chk("bp_hold_id",    RSP_ID, 0);
         chk("bp_hold_ready", REQ_READY, 0);
      end
      RSP_READY = 1'b1;
      step();
      #1;
      chk("bp_release_valid", RSP_VALID, 0);
      chk("bp_release_ready", REQ_READY, 2'b10);
      step();
      REQ_VALID = 2'b00;
      #1;
      chk("bp_req1_en",  en, 4'b0010);
      chk("bp_req1_fun", ALU_FUN, 2'b11);
      step();
      step();
      #1;
      chk("bp_req1_valid", RSP_VALID, 1);
      chk("bp_req1_id",    RSP_ID, 1);
      chk("bp_req1_data",  RSP_DATA, 16'hFFFF);
      step();

      // Reset while waiting for the ALU result
      REQ_A[15:0]  = 16'h0010;
      REQ_B[15:0]  = 16'h0003;
      REQ_FUN[3:0] = 4'b0001;
      REQ_VALID    = 2'b01;
      #1;
      chk("mid_ready", REQ_READY, 2'b01);
      step();
      REQ_VALID = 2'b00;
      step();
      #1;
      chk("mid_wait_flag", OUT_VALID, 1);
      RST = 1'b1;
      step();
      #1;
      chk("mid_rst_valid", RSP_VALID, 0);
      chk("mid_rst_en",    en, 0);
      chk("mid_rst_a",     ALU_A, 0);
      chk("mid_rst_data",  RSP_DATA, 0);
      RST = 1'b0;
      step();
      #1;
      chk("mid_after_valid", RSP_VALID, 0);
      REQ_A[31:16] = 16'h00F0;
      REQ_B[31:16] = 16'h0F00;
      REQ_FUN[7:4] = 4'b0101;
      REQ_VALID    = 2'b10;
      #1;
      chk("mid_next_ready", REQ_READY, 2'b10);
      step();
      REQ_VALID = 2'b00;
      step();
      step();
      #1;
      chk("mid_next_valid", RSP_VALID, 1);
      chk("mid_next_id",    RSP_ID, 1);
      chk("mid_next_data",  RSP_DATA, 16'h0FF0);
      step();

`ifdef ALU_OP_ARBITER_TIMEOUT_EN
      // ALU never answers: error response after 8 WAIT cycles
      alu_kill     = 1'b1;
      REQ_A[15:0]  = 16'hFFFF;
      REQ_B[15:0]  = 16'h1234;
      REQ_FUN[3:0] = 4'b0100;
      REQ_VALID    = 2'b01;
      #1;
      chk("to_ready", REQ_READY, 2'b01);
      step();
      REQ_VALID = 2'b00;
      step();
      for (int w = 0; w < 8; w++) begin
         #1;
         chk("to_wait_valid", RSP_VALID, 0);
         chk("to_wait_err",   RSP_ERR, 0);
         step();
      end
      #1;
      chk("to_rsp_valid", RSP_VALID, 1);
      chk("to_rsp_err",   RSP_ERR, 1);
      chk("to_rsp_data",  RSP_DATA, 0);
      chk("to_rsp_id",    RSP_ID, 0);
      step();
      #1;
      chk("to_clr_valid", RSP_VALID, 0);
      chk("to_clr_err",   RSP_ERR, 0);
      alu_kill = 1'b0;
`else
      chk("no_to_err", RSP_ERR, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
